// File: rtl/s_axis_cc_adapt_x8_pkg.sv
// Shared constants for the LitePCIe-to-UltraScale CC completion adapter:
// legacy header offsets, CC descriptor bit positions and completion type codes.
package s_axis_cc_adapt_x8_pkg;

  localparam int CC_DW_PER_BEAT = 8;
  localparam int CC_TUSER_W     = 33;
  localparam int CC_PAYLOAD_W   = 256 + 8 + 1 + CC_TUSER_W;

  // Dword base offsets of the 3DW legacy header inside a beat
  localparam int LG_DW0 = 0;
  localparam int LG_DW1 = 32;
  localparam int LG_DW2 = 64;

  localparam int LG_FMT_LSB    = 29;
  localparam int LG_TYPE_LSB   = 24;
  localparam int LG_TC_LSB     = 20;
  localparam int LG_EP_BIT     = 14;
  localparam int LG_ATTR_LSB   = 12;
  localparam int LG_LEN_LSB    = 0;
  localparam int LG_CPLID_LSB  = 16;
  localparam int LG_STATUS_LSB = 13;
  localparam int LG_BC_LSB     = 0;
  localparam int LG_REQID_LSB  = 16;
  localparam int LG_TAG_LSB    = 8;
  localparam int LG_LADDR_LSB  = 0;

  localparam int CC_LADDR_LSB  = 0;
  localparam int CC_BC_LSB     = 16;
  localparam int CC_LOCKED_BIT = 29;
  localparam int CC_DWCNT_LSB  = 0;
  localparam int CC_STATUS_LSB = 11;
  localparam int CC_EP_BIT     = 14;
  localparam int CC_REQID_LSB  = 16;
  localparam int CC_TAG_LSB    = 0;
  localparam int CC_CPLID_LSB  = 8;
  localparam int CC_TC_LSB     = 25;
  localparam int CC_ATTR_LSB   = 28;

  typedef enum logic [4:0] {
    TLP_TYPE_CPL   = 5'b01010,
    TLP_TYPE_CPLLK = 5'b01011
  } cpl_type_e;

  // Beats a packet should occupy: 3 header dwords plus payload, rounded up to whole beats
  function automatic logic [7:0] expected_beats(input logic has_data, input logic [9:0] len);
    logic [10:0] dws;
    dws = 11'd3 + (has_data ? ((len == 10'd0) ? 11'd1024 : {1'b0, len}) : 11'd0);
    return 8'((dws + 11'(CC_DW_PER_BEAT - 1)) >> $clog2(CC_DW_PER_BEAT));
  endfunction

endpackage

// File: rtl/s_axis_cc_adapt_x8_skid.sv
// Two-entry register slice (main + skid). Input ready is registered and
// only drops while the skid entry holds a beat.
module axis_skid_buffer_256
  import s_axis_cc_adapt_x8_pkg::*;
#(
  parameter int WIDTH = CC_PAYLOAD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q, ready_d;
  logic             accept;

  assign accept      = in_valid_i & ready_q;
  assign in_ready_o  = ready_q;
  assign out_data_o  = main_q;
  assign out_valid_o = main_valid_q;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_ready_i || !main_valid_q) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_data_i;
      end
    end else if (accept) begin
      skid_d       = in_data_i;
      skid_valid_d = 1'b1;
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

endmodule

// File: rtl/s_axis_cc_adapt_x8.sv
// LitePCIe completion TLP to UltraScale CC descriptor adapter (256-bit).
// Remaps the SOP header, reduces keep to dwords and flags length mismatches via discontinue.
module s_axis_cc_adapt_x8
  import s_axis_cc_adapt_x8_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_cc_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_cc_tkeep,
  input  logic                  s_axis_cc_tlast,
  input  logic                  s_axis_cc_tvalid,
  output logic                  s_axis_cc_tready,
  output logic [DATA_WIDTH-1:0] s_axis_cc_tdata_a,
  output logic [7:0]            s_axis_cc_tkeep_a,
  output logic                  s_axis_cc_tlast_a,
  output logic [32:0]           s_axis_cc_tuser_a,
  output logic                  s_axis_cc_tvalid_a,
  input  logic [3:0]            s_axis_cc_tready_a
);

  logic                  in_pkt_q, in_pkt_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [7:0]            exp_beats_q, exp_beats_d;
  logic                  mis_q, mis_d;
  logic                  accept, sop, beat_bad, disc;
  logic [7:0]            beat_idx, beats_exp;
  logic [9:0]            len;
  logic                  has_data;
  logic [4:0]            tlp_type;
  logic [31:0]           cc0, cc1, cc2;
  logic [DATA_WIDTH-1:0] data_conv;
  logic [7:0]            keep_conv;
  logic                  unused_tready_a;

  assign unused_tready_a = ^s_axis_cc_tready_a[3:1];
  assign accept   = s_axis_cc_tvalid & s_axis_cc_tready;
  assign sop      = ~in_pkt_q;
  assign len      = s_axis_cc_tdata[LG_DW0 + LG_LEN_LSB +: 10];
  assign has_data = s_axis_cc_tdata[LG_DW0 + LG_FMT_LSB + 1];
  assign tlp_type = s_axis_cc_tdata[LG_DW0 + LG_TYPE_LSB +: 5];

  always_comb begin
    cc0 = '0;
    cc0[CC_LADDR_LSB +: 7]  = s_axis_cc_tdata[LG_DW2 + LG_LADDR_LSB +: 7];
    cc0[CC_BC_LSB +: 13]    = {1'b0, s_axis_cc_tdata[LG_DW1 + LG_BC_LSB +: 12]};
    cc0[CC_LOCKED_BIT]      = (tlp_type == TLP_TYPE_CPLLK);
    cc1 = '0;
    // A zero length field with data means 1024 dwords; bit 10 of the CC count carries that
    cc1[CC_DWCNT_LSB +: 11] = {(len == 10'd0) && has_data, len};
    cc1[CC_STATUS_LSB +: 3] = s_axis_cc_tdata[LG_DW1 + LG_STATUS_LSB +: 3];
    cc1[CC_EP_BIT]          = s_axis_cc_tdata[LG_DW0 + LG_EP_BIT];
    cc1[CC_REQID_LSB +: 16] = s_axis_cc_tdata[LG_DW2 + LG_REQID_LSB +: 16];
    cc2 = '0;
    cc2[CC_TAG_LSB +: 8]    = s_axis_cc_tdata[LG_DW2 + LG_TAG_LSB +: 8];
    cc2[CC_CPLID_LSB +: 16] = s_axis_cc_tdata[LG_DW1 + LG_CPLID_LSB +: 16];
    cc2[CC_TC_LSB +: 3]     = s_axis_cc_tdata[LG_DW0 + LG_TC_LSB +: 3];
    cc2[CC_ATTR_LSB +: 3]   = {1'b0, s_axis_cc_tdata[LG_DW0 + LG_ATTR_LSB +: 2]};
    data_conv = s_axis_cc_tdata;
    if (sop) data_conv[95:0] = {cc2, cc1, cc0};
    for (int i = 0; i < 8; i++) keep_conv[i] = |s_axis_cc_tkeep[4*i +: 4];
  end

  always_comb begin
    in_pkt_d    = in_pkt_q;
    beat_cnt_d  = beat_cnt_q;
    exp_beats_d = exp_beats_q;
    mis_d       = mis_q;
    beat_idx    = sop ? 8'd1 : ((beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1);
    beats_exp   = sop ? expected_beats(has_data, len) : exp_beats_q;
    beat_bad    = s_axis_cc_tlast ? (beat_idx != beats_exp) : (beat_idx == beats_exp);
    disc        = s_axis_cc_tlast & (beat_bad | mis_q);
    if (accept) begin
      in_pkt_d    = ~s_axis_cc_tlast;
      beat_cnt_d  = s_axis_cc_tlast ? 8'd0 : beat_idx;
      exp_beats_d = beats_exp;
      mis_d       = s_axis_cc_tlast ? 1'b0 : (mis_q | beat_bad);
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      in_pkt_q    <= 1'b0;
      beat_cnt_q  <= 8'd0;
      exp_beats_q <= 8'd0;
      mis_q       <= 1'b0;
    end else begin
      in_pkt_q    <= in_pkt_d;
      beat_cnt_q  <= beat_cnt_d;
      exp_beats_q <= exp_beats_d;
      mis_q       <= mis_d;
    end
  end

  axis_skid_buffer_256 #(
    .WIDTH(DATA_WIDTH + 8 + 1 + CC_TUSER_W)
  ) u_slice (
    .clk        (user_clk),
    .rst_n      (user_reset_n),
    .in_data_i  ({data_conv, keep_conv, s_axis_cc_tlast, {32'b0, disc}}),
    .in_valid_i (s_axis_cc_tvalid),
    .in_ready_o (s_axis_cc_tready),
    .out_data_o ({s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tuser_a}),
    .out_valid_o(s_axis_cc_tvalid_a),
    .out_ready_i(s_axis_cc_tready_a[0])
  );

endmodule
